// File: rtl/maxpool_2x2_1x8_pkg.sv
// Shared lane geometry, bundle type and FSM encoding for the 2x2 max-pool stage.
package maxpool_2x2_1x8_pkg;
  localparam int unsigned LANES    = 8;
  localparam int unsigned LANE_W   = 8;
  localparam int unsigned BUNDLE_W = LANES * LANE_W;

  typedef logic [LANES-1:0][LANE_W-1:0] bundle_t;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;
endpackage

// File: rtl/row_buffer_sdp.sv
// Simple dual-port row buffer: one write port, one synchronous read port (1-cycle latency).
module row_buffer_sdp
  import maxpool_2x2_1x8_pkg::*;
#(
  parameter int unsigned DEPTH = 208,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  bundle_t       wdata_i,
  input  logic          re_i,
  input  logic [AW-1:0] raddr_i,
  output bundle_t       rdata_o
);

  bundle_t mem [DEPTH];

  // No reset on storage or read register so the array maps onto block RAM.
  always_ff @(posedge clk) begin
    if (we_i) mem[waddr_i] <= wdata_i;
    if (re_i) rdata_o <= mem[raddr_i];
  end

endmodule

// File: rtl/maxpool_2x2_1x8.sv
// 8-lane uint8 2x2/stride-2 max-pool over a raster pixel stream, one output per window.
module maxpool_2x2_1x8
  import maxpool_2x2_1x8_pkg::*;
#(
  parameter int unsigned MAX_WIDTH = 416,
  parameter int unsigned DIM_W     = 10
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [DIM_W-1:0]    img_width,
  input  logic [DIM_W-1:0]    img_height,
  input  logic                start,
  input  logic                bundle_in_valid,
  input  logic [BUNDLE_W-1:0] bundle_in,
  output logic                bundle_out_valid,
  output logic [BUNDLE_W-1:0] bundle_out,
  output logic                frame_done,
  output logic                busy
);

  localparam int unsigned DEPTH = MAX_WIDTH / 2;
  localparam int unsigned AW    = $clog2(DEPTH);

  state_e           state_q, state_d;
  logic [DIM_W-1:0] width_q, height_q, col_q, row_q, col_d, row_d;
  logic [DIM_W-1:0] w_eff, h_eff, col_eff, row_eff;
  logic [AW-1:0]    addr_c;
  bundle_t          in_c, pair_q, h_c, h_q, rd_data, out_max_c, out_q;
  logic             run_c, accept_c, last_col_c, final_c, pool_c, wr_c, rd_c;
  logic             s1_valid_q, s1_done_q, out_valid_q, done_q;

  assign in_c = bundle_in;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic; start while running keeps RUN
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (start) state_d = ST_RUN;
      ST_RUN:  if (final_c && !start) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    run_c    = (state_q == ST_RUN);
    accept_c = bundle_in_valid && (run_c || start);
  end

  // A beat coincident with start uses the fresh dimensions and position (0,0)
  always_comb begin
    w_eff      = start ? img_width  : width_q;
    h_eff      = start ? img_height : height_q;
    col_eff    = start ? '0 : col_q;
    row_eff    = start ? '0 : row_q;
    last_col_c = (col_eff == w_eff - DIM_W'(1));
    final_c    = accept_c && last_col_c && (row_eff == h_eff - DIM_W'(1));
    pool_c     = accept_c && col_eff[0];
    wr_c       = pool_c && !row_eff[0];
    rd_c       = pool_c && row_eff[0];
    addr_c     = AW'(col_eff >> 1);
    col_d      = col_eff;
    row_d      = row_eff;
    if (accept_c) begin
      if (last_col_c) begin
        col_d = '0;
        row_d = final_c ? '0 : row_eff + DIM_W'(1);
      end else begin
        col_d = col_eff + DIM_W'(1);
      end
    end
  end

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    assign h_c[k]       = (in_c[k] > pair_q[k]) ? in_c[k] : pair_q[k];
    assign out_max_c[k] = (rd_data[k] > h_q[k]) ? rd_data[k] : h_q[k];
  end

  row_buffer_sdp #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_row_buf (
    .clk     (clk),
    .we_i    (wr_c),
    .waddr_i (addr_c),
    .wdata_i (h_c),
    .re_i    (rd_c),
    .raddr_i (addr_c),
    .rdata_o (rd_data)
  );

  // Counters, pair register and the two-stage output pipeline
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      width_q     <= '0;
      height_q    <= '0;
      col_q       <= '0;
      row_q       <= '0;
      pair_q      <= '0;
      h_q         <= '0;
      s1_valid_q  <= 1'b0;
      s1_done_q   <= 1'b0;
      out_valid_q <= 1'b0;
      out_q       <= '0;
      done_q      <= 1'b0;
    end else begin
      col_q <= col_d;
      row_q <= row_d;
      if (start) begin
        width_q  <= img_width;
        height_q <= img_height;
      end
      if (accept_c && !col_eff[0]) pair_q <= in_c;
      if (pool_c) h_q <= h_c;
      s1_valid_q  <= rd_c;
      s1_done_q   <= final_c;
      out_valid_q <= s1_valid_q && !start;
      done_q      <= s1_done_q && !start;
      if (s1_valid_q && !start) out_q <= out_max_c;
    end
  end

  assign bundle_out_valid = out_valid_q;
  assign bundle_out       = out_q;
  assign frame_done       = done_q;
  assign busy             = run_c;

endmodule

// File: tb/tb_maxpool_2x2_1x8.sv
// Self-checking bench for maxpool_2x2_1x8 against a floor-pooling reference model.
module tb_maxpool_2x2_1x8;
  localparam int unsigned DIM_W = 10;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [DIM_W-1:0] img_width, img_height;
  logic             start, bundle_in_valid;
  logic [63:0]      bundle_in;
  logic             bundle_out_valid;
  logic [63:0]      bundle_out;
  logic             frame_done, busy;

  logic [63:0] pix_q[$];
  logic [63:0] exp_data_q[$];
  logic [63:0] got_data_q[$];
  int          exp_cyc_q[$];
  int          got_cyc_q[$];
  int          done_cyc_q[$];
  int          cyc = 0;
  int          last_cyc = 0;
  int          checks = 0;
  int          errors = 0;

  maxpool_2x2_1x8 dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .img_width        (img_width),
    .img_height       (img_height),
    .start            (start),
    .bundle_in_valid  (bundle_in_valid),
    .bundle_in        (bundle_in),
    .bundle_out_valid (bundle_out_valid),
    .bundle_out       (bundle_out),
    .frame_done       (frame_done),
    .busy             (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rst_n) begin
      if (bundle_out_valid) begin
        got_data_q.push_back(bundle_out);
        got_cyc_q.push_back(cyc);
      end
      if (frame_done) done_cyc_q.push_back(cyc);
    end
  end

  task automatic gen_random(input int n);
    pix_q.delete();
    for (int i = 0; i < n; i++) pix_q.push_back({$urandom, $urandom});
  endtask

  // Reference: each output lane is the largest of the four window pixels' lanes.
  function automatic void build_model(input int w, input int h);
    logic [63:0] o;
    logic [7:0]  m, v;
    exp_data_q.delete();
    for (int pr = 0; pr < h / 2; pr++)
      for (int pc = 0; pc < w / 2; pc++) begin
        o = '0;
        for (int k = 0; k < 8; k++) begin
          m = 8'd0;
          for (int dy = 0; dy < 2; dy++)
            for (int dx = 0; dx < 2; dx++) begin
              v = pix_q[(2 * pr + dy) * w + 2 * pc + dx][8 * k +: 8];
              if (v > m) m = v;
            end
          o[8 * k +: 8] = m;
        end
        exp_data_q.push_back(o);
      end
  endfunction

  // Starts a frame at the current negedge and drives n beats of pix_q; returns one cycle after the last beat.
  task automatic run_frame(input int w, input int h, input int n, input int gap_pct, input bit coincide);
    int i;
    exp_cyc_q.delete();
    img_width  = DIM_W'(w);
    img_height = DIM_W'(h);
    start      = 1'b1;
    i          = 0;
    bundle_in_valid = 1'b0;
    if (coincide) begin
      bundle_in_valid = 1'b1;
      bundle_in       = pix_q[0];
      last_cyc        = cyc;
      i               = 1;
    end
    #1;
    got_data_q.delete();
    got_cyc_q.delete();
    done_cyc_q.delete();
    @(negedge clk);
    start = 1'b0;
    while (i < n) begin
      if (gap_pct > 0 && $urandom_range(99) < gap_pct) begin
        bundle_in_valid = 1'b0;
        bundle_in       = {$urandom, $urandom};
      end else begin
        bundle_in_valid = 1'b1;
        bundle_in       = pix_q[i];
        if (((i / w) % 2 == 1) && ((i % w) % 2 == 1)) exp_cyc_q.push_back(cyc + 2);
        last_cyc = cyc;
        i++;
      end
      @(negedge clk);
    end
    bundle_in_valid = 1'b0;
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    checks++; if (bundle_out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", bundle_out_valid); end
    checks++; if (bundle_out !== 64'd0) begin errors++; $display("FAIL reset_data: got %h expected 0", bundle_out); end
    checks++; if (frame_done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", frame_done); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_maxpool_basic();
    int r0[4];
    int r1[4];
    logic [63:0] p, e0, e1;
    r0 = '{1, 5, 2, 9};
    r1 = '{3, 0, 7, 4};
    pix_q.delete();
    for (int c = 0; c < 4; c++) begin
      for (int k = 0; k < 8; k++) p[8 * k +: 8] = 8'(r0[c] + k);
      pix_q.push_back(p);
    end
    for (int c = 0; c < 4; c++) begin
      for (int k = 0; k < 8; k++) p[8 * k +: 8] = 8'(r1[c] + k);
      pix_q.push_back(p);
    end
    for (int k = 0; k < 8; k++) begin
      e0[8 * k +: 8] = 8'(5 + k);
      e1[8 * k +: 8] = 8'(9 + k);
    end
    run_frame(4, 2, 8, 0, 1'b0);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL basic_busy_drop: got %b expected 0", busy); end
    repeat (4) @(negedge clk);
    checks++; if (got_data_q.size() !== 2) begin errors++; $display("FAIL basic_count: got %0d expected 2", got_data_q.size()); end
    if (got_data_q.size() == 2) begin
      checks++; if (got_data_q[0] !== e0) begin errors++; $display("FAIL basic_out0: got %h expected %h", got_data_q[0], e0); end
      checks++; if (got_data_q[1] !== e1) begin errors++; $display("FAIL basic_out1: got %h expected %h", got_data_q[1], e1); end
      for (int j = 0; j < 2; j++) begin
        checks++; if (got_cyc_q[j] !== exp_cyc_q[j]) begin errors++; $display("FAIL basic_latency%0d: got cycle %0d expected %0d", j, got_cyc_q[j], exp_cyc_q[j]); end
      end
    end
    checks++; if (done_cyc_q.size() !== 1 || done_cyc_q[0] !== last_cyc + 2) begin errors++; $display("FAIL basic_done: got %0d pulses expected 1 at cycle %0d", done_cyc_q.size(), last_cyc + 2); end
  endtask

  task automatic test_unsigned();
    pix_q.delete();
    pix_q.push_back({8{8'h80}});
    pix_q.push_back({8{8'h7F}});
    pix_q.push_back({8{8'hFF}});
    pix_q.push_back({8{8'h00}});
    run_frame(2, 2, 4, 0, 1'b0);
    repeat (4) @(negedge clk);
    checks++; if (got_data_q.size() !== 1) begin errors++; $display("FAIL unsigned_count: got %0d expected 1", got_data_q.size()); end
    else begin
      checks++; if (got_data_q[0] !== {8{8'hFF}}) begin errors++; $display("FAIL unsigned_max: got %h expected %h", got_data_q[0], {8{8'hFF}}); end
    end
  endtask

  task automatic test_odd_dims();
    gen_random(15);
    build_model(5, 3);
    run_frame(5, 3, 15, 0, 1'b0);
    repeat (4) @(negedge clk);
    checks++; if (got_data_q.size() !== 2 || exp_data_q.size() !== 2) begin errors++; $display("FAIL odd_count: got %0d expected 2", got_data_q.size()); end
    for (int j = 0; j < exp_data_q.size() && j < got_data_q.size(); j++) begin
      checks++; if (got_data_q[j] !== exp_data_q[j]) begin errors++; $display("FAIL odd_data%0d: got %h expected %h", j, got_data_q[j], exp_data_q[j]); end
      checks++; if (got_cyc_q[j] !== exp_cyc_q[j]) begin errors++; $display("FAIL odd_latency%0d: got cycle %0d expected %0d", j, got_cyc_q[j], exp_cyc_q[j]); end
    end
    checks++; if (done_cyc_q.size() !== 1 || done_cyc_q[0] !== last_cyc + 2) begin errors++; $display("FAIL odd_done: got %0d pulses expected 1 at cycle %0d", done_cyc_q.size(), last_cyc + 2); end
  endtask

  task automatic test_valid_gaps();
    logic [63:0] ref_q[$];
    gen_random(32);
    build_model(8, 4);
    run_frame(8, 4, 32, 0, 1'b0);
    repeat (4) @(negedge clk);
    ref_q = got_data_q;
    run_frame(8, 4, 32, 50, 1'b0);
    repeat (4) @(negedge clk);
    checks++; if (got_data_q.size() !== 8 || ref_q.size() !== 8) begin errors++; $display("FAIL gaps_count: got %0d and %0d expected 8", ref_q.size(), got_data_q.size()); end
    for (int j = 0; j < exp_data_q.size() && j < got_data_q.size() && j < ref_q.size(); j++) begin
      checks++; if (got_data_q[j] !== exp_data_q[j]) begin errors++; $display("FAIL gaps_data%0d: got %h expected %h", j, got_data_q[j], exp_data_q[j]); end
      checks++; if (ref_q[j] !== exp_data_q[j]) begin errors++; $display("FAIL nogap_data%0d: got %h expected %h", j, ref_q[j], exp_data_q[j]); end
      checks++; if (got_cyc_q[j] !== exp_cyc_q[j]) begin errors++; $display("FAIL gaps_latency%0d: got cycle %0d expected %0d", j, got_cyc_q[j], exp_cyc_q[j]); end
    end
    checks++; if (done_cyc_q.size() !== 1 || done_cyc_q[0] !== last_cyc + 2) begin errors++; $display("FAIL gaps_done: got %0d pulses expected 1 at cycle %0d", done_cyc_q.size(), last_cyc + 2); end
  endtask

  task automatic test_restart();
    int n_bad;
    gen_random(832);
    // Abandon right after an odd/odd beat so an old output is still in flight at restart.
    run_frame(416, 2, 416 + 102, 0, 1'b0);
    gen_random(832);
    build_model(416, 2);
    run_frame(416, 2, 832, 0, 1'b0);
    repeat (4) @(negedge clk);
    checks++; if (got_data_q.size() !== 208) begin errors++; $display("FAIL restart_count: got %0d expected 208", got_data_q.size()); end
    n_bad = 0;
    for (int j = 0; j < exp_data_q.size() && j < got_data_q.size(); j++)
      if (got_data_q[j] !== exp_data_q[j] || got_cyc_q[j] !== exp_cyc_q[j]) n_bad++;
    checks++; if (n_bad !== 0) begin errors++; $display("FAIL restart_data: got %0d wrong outputs expected 0", n_bad); end
    checks++; if (done_cyc_q.size() !== 1 || done_cyc_q[0] !== last_cyc + 2) begin errors++; $display("FAIL restart_done: got %0d pulses expected 1 at cycle %0d", done_cyc_q.size(), last_cyc + 2); end
  endtask

  task automatic test_reset_midframe();
    gen_random(32);
    run_frame(8, 4, 20, 0, 1'b0);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL midframe_busy: got %b expected 1", busy); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (bundle_out_valid !== 1'b0) begin errors++; $display("FAIL rst_async_valid: got %b expected 0", bundle_out_valid); end
    checks++; if (bundle_out !== 64'd0) begin errors++; $display("FAIL rst_async_data: got %h expected 0", bundle_out); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_async_busy: got %b expected 0", busy); end
    @(negedge clk);
    rst_n = 1'b1;
    got_data_q.delete();
    got_cyc_q.delete();
    done_cyc_q.delete();
    for (int i = 0; i < 12; i++) begin
      bundle_in_valid = 1'b1;
      bundle_in       = {$urandom, $urandom};
      @(negedge clk);
    end
    bundle_in_valid = 1'b0;
    repeat (4) @(negedge clk);
    checks++; if (got_data_q.size() !== 0 || done_cyc_q.size() !== 0) begin errors++; $display("FAIL rst_ignore: got %0d outputs and %0d done expected 0", got_data_q.size(), done_cyc_q.size()); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_idle_busy: got %b expected 0", busy); end
  endtask

  task automatic test_coincident();
    gen_random(4);
    build_model(2, 2);
    run_frame(2, 2, 4, 0, 1'b1);
    repeat (4) @(negedge clk);
    checks++; if (got_data_q.size() !== 1) begin errors++; $display("FAIL coinc_count: got %0d expected 1", got_data_q.size()); end
    else begin
      checks++; if (got_data_q[0] !== exp_data_q[0]) begin errors++; $display("FAIL coinc_data: got %h expected %h", got_data_q[0], exp_data_q[0]); end
      checks++; if (got_cyc_q[0] !== last_cyc + 2) begin errors++; $display("FAIL coinc_latency: got cycle %0d expected %0d", got_cyc_q[0], last_cyc + 2); end
    end
    checks++; if (done_cyc_q.size() !== 1 || done_cyc_q[0] !== last_cyc + 2) begin errors++; $display("FAIL coinc_done: got %0d pulses expected 1 at cycle %0d", done_cyc_q.size(), last_cyc + 2); end
  endtask

  initial begin
    start           = 1'b0;
    bundle_in_valid = 1'b0;
    bundle_in       = '0;
    img_width       = '0;
    img_height      = '0;
    test_reset();
    test_maxpool_basic();
    test_unsigned();
    test_odd_dims();
    test_valid_gaps();
    test_restart();
    test_reset_midframe();
    test_coincident();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/maxpool_2x2_1x8.md
# maxpool_2x2_1x8

Downstream consumer of the 8-lane ReLU stage. Takes the 64-bit bundle (8 channels × uint8 for one pixel, raster order) and performs a 2×2, stride-2 max-pool per lane. A half-width row buffer holds the horizontal maxima of even rows. The block emits one pooled 64-bit bundle per 2×2 window, towards the output write-back path.

## Interface
- `MAX_WIDTH`, 416: largest supported input width in pixels; row buffer depth is `MAX_WIDTH/2`.
- `DIM_W`, 10: width of the dimension inputs and the internal row/column counters.
- `clk` in 1: single clock, all logic rising-edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `img_width` in `DIM_W`: input width in pixels, sampled on `start`; range 2..`MAX_WIDTH`.
- `img_height` in `DIM_W`: input height in rows, sampled on `start`; range ≥2.
- `start` in 1: one-cycle pulse that begins a frame.
- `bundle_in_valid` in 1: `bundle_in` carries one pixel this cycle. There is no backpressure.
- `bundle_in` in 64: lane k in bits [8k+7:8k], k = 0..7.
- `bundle_out_valid` out 1: pooled bundle present this cycle.
- `bundle_out` out 64: pooled result, same lane packing as `bundle_in`.
- `frame_done` out 1: one-cycle pulse marking the end of the frame.
- `busy` out 1: high while the FSM is in RUN.

## Operation
- FSM states:
  - IDLE: input beats are ignored.
  - RUN: input beats are counted and pooled.
- Transitions:
  - IDLE→RUN on `start`.
  - RUN→IDLE on the accepted beat at (row `img_height`-1, col `img_width`-1).
  - `start` in RUN restarts the frame: counters clear, pipeline valids clear, and the FSM stays in RUN.
- Counters:
  - `col` runs 0..`img_width`-1 and wraps to 0 while `row` increments.
  - `row` runs 0..`img_height`-1.
  - Both clear on `start`.
  - If `start` and `bundle_in_valid` coincide, the beat is taken as (row 0, col 0).
- Per-lane arithmetic is an unsigned 8-bit max. Quantized values are monotonic in real value, so `zero_point` is not needed.
- Even col: `bundle_in` is latched into the pair register.
- Odd col: h = lanewise max(pair register, `bundle_in`).
  - Even row: h is written to the row buffer at address col>>1.
  - Odd row: the row buffer is read at col>>1, and the output is lanewise max(buffer word, h).
- Odd `img_width`: the last column of every row has no partner. It is latched but never used, so output width is floor(W/2).
- Odd `img_height`: the last row is written to the buffer and never read, so output height is floor(H/2).
- Row-buffer ordering: an odd-row read at address a always follows the even-row write at a by at least one row. No bypass is needed.

## Timing
- Reset values:
  - FSM = IDLE.
  - `bundle_out_valid` = 0, `bundle_out` = 0.
  - `frame_done` = 0, `busy` = 0.
  - Counters and pair register = 0.
- Reset mid-frame abandons the frame with no output. Row-buffer contents are undefined after reset and are never read before being rewritten.
- Pipeline for an accepted beat in cycle t:
  - t: h is formed combinationally; the buffer read (or write address) is issued.
  - t+1: h is registered and the buffer data returns. An even-row write commits here.
  - t+2: `bundle_out` / `bundle_out_valid` are registered.
- Latency from the (odd row, odd col) input beat to `bundle_out_valid` is exactly 2 cycles.
- `frame_done` pulses 2 cycles after the final beat. It coincides with the last `bundle_out_valid` when H and W are both even.
- `busy` drops in cycle t+1 after the final beat.
- Gaps in `bundle_in_valid` are allowed anywhere and do not advance counters. The output rate is at most 1 per 4 input beats.
- `start` clears any in-flight outputs: no `bundle_out_valid` appears in the following 2 cycles from the old frame.

## Structure
- The shared package / header holds `LANES`=8, `LANE_W`=8, `BUNDLE_W`=64, and the FSM state encodings (IDLE=0, RUN=1).
- One sub-module, `row_buffer_sdp`:
  - Simple dual-port RAM, 64-bit wide, depth `MAX_WIDTH/2`.
  - Synchronous read with 1-cycle latency, one write port.
  - Must infer BRAM.
- The lanewise max is a generate loop inside the top module; it gets no separate module.

## Test plan
- Max-pool correctness: W=4, H=2; row0 lane k = {1,5,2,9}+k, row1 = {3,0,7,4}+k. Expect 2 outputs, lane k = {5+k, 9+k}, each 2 cycles after row1 beats col1/col3, then `frame_done`.
- Unsigned compare: all lanes 0x80 vs 0x7F vs 0xFF vs 0x00 in one window. Expect 0xFF on every lane.
- Odd dimensions: W=5, H=3, random data, continuous valid. Expect exactly 2 outputs matching the floor-pooling model, and `frame_done` 2 cycles after beat (2,4).
- Valid gaps: W=8, H=4 with random `bundle_in_valid` (~50%). Expect 8 outputs identical to the gap-free run; no output ever appears without a pending odd/odd beat.
- Restart and reset: `start` mid-row-1 of a W=416 frame, then a full 416×2 frame. Expect 208 outputs from the new frame only. Also deassert `rst_n` mid-frame: outputs go to 0 asynchronously, and beats are ignored until the next `start`.
- Coincident start/valid: `start` and `bundle_in_valid` in the same cycle, W=2, H=2. Expect the beat taken as (0,0) and one output after the 4th beat.
